// File: rtl/ps2_mouse_pkg.sv
// rtl/ps2_mouse_pkg.sv - shared states, PS/2 command/response codes and init-sequence helpers
package ps2_mouse_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SEND     = 4'd1,
    ST_WAIT_ACK = 4'd2,
    ST_WAIT_BAT = 4'd3,
    ST_WAIT_ID  = 4'd4,
    ST_STREAM   = 4'd5,
    ST_FAIL     = 4'd6
  } state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERROR    = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ID_WHEEL = 8'h03;

  // Slot of F2 in the wheel-enabled sequence; only meaningful when wheel detect is on.
  localparam logic [3:0] GET_ID_IDX = 4'd7;

  function automatic logic [3:0] seq_len(input logic enable_wheel);
    return enable_wheel ? 4'd11 : 4'd4;
  endfunction

  // Without wheel detect the seven knock bytes are skipped, so indices past 0 map 7 slots later.
  function automatic logic [7:0] cmd_at(input logic [3:0] idx, input logic enable_wheel,
                                        input logic [7:0] sample_rate);
    logic [3:0] slot;
    slot = (enable_wheel || idx == 4'd0) ? idx : idx + 4'd7;
    case (slot)
      4'd0:                   return CMD_RESET;
      4'd1, 4'd3, 4'd5, 4'd8: return CMD_SET_RATE;
      4'd2:                   return 8'hC8;
      4'd4:                   return 8'h64;
      4'd6:                   return 8'h50;
      4'd7:                   return CMD_GET_ID;
      4'd9:                   return sample_rate;
      default:                return CMD_ENABLE;
    endcase
  endfunction

  // Decided by position, not byte value, so an argument byte equal to F2 is not mistaken for it.
  function automatic logic is_get_id_idx(input logic [3:0] idx, input logic enable_wheel);
    return enable_wheel && (idx == GET_ID_IDX);
  endfunction

endpackage

// File: rtl/ps2_mouse_pkt_assembler.sv
// rtl/ps2_mouse_pkt_assembler.sv - stream packet sync, byte counting, inter-byte timeout and publish
module ps2_mouse_pkt_assembler #(
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       active_i,
  input  logic       wheel_mode_i,
  input  logic       byte_ready_i,
  input  logic [7:0] byte_read_i,
  input  logic       rx_ok_i,
  output logic [7:0] mouse_status_o,
  output logic [7:0] mouse_dx_o,
  output logic [7:0] mouse_dy_o,
  output logic [7:0] mouse_dz_o,
  output logic       send_interrupt_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    cnt_q, cnt_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [TW-1:0] gap_q, gap_d;
  logic [7:0]    st_q, st_d, dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
  logic          irq_q, irq_d;
  logic [1:0]    last_cnt;

  assign last_cnt = wheel_mode_i ? 2'd3 : 2'd2;

  // Collect bytes into staging registers; publish all outputs together on the final byte.
  always_comb begin
    cnt_d = cnt_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    b2_d  = b2_q;
    gap_d = gap_q;
    st_d  = st_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    dz_d  = dz_q;
    irq_d = 1'b0;
    if (active_i) begin
      if (byte_ready_i) begin
        gap_d = '0;
        if (!rx_ok_i) begin
          cnt_d = 2'd0;
        end else if (cnt_q == 2'd0) begin
          if (byte_read_i[3]) begin
            b0_d  = byte_read_i;
            cnt_d = 2'd1;
          end
        end else if (cnt_q == last_cnt) begin
          st_d  = b0_q;
          dx_d  = b1_q;
          dy_d  = wheel_mode_i ? b2_q : byte_read_i;
          dz_d  = wheel_mode_i ? {{4{byte_read_i[3]}}, byte_read_i[3:0]} : 8'h00;
          irq_d = 1'b1;
          cnt_d = 2'd0;
        end else begin
          if (cnt_q == 2'd1) b1_d = byte_read_i;
          else               b2_d = byte_read_i;
          cnt_d = cnt_q + 2'd1;
        end
      end else if (cnt_q != 2'd0) begin
        if (gap_q == T_LAST) begin
          cnt_d = 2'd0;
          gap_d = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    end
  end

  // Packet state and published outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      b0_q  <= 8'h00;
      b1_q  <= 8'h00;
      b2_q  <= 8'h00;
      gap_q <= '0;
      st_q  <= 8'h00;
      dx_q  <= 8'h00;
      dy_q  <= 8'h00;
      dz_q  <= 8'h00;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      b2_q  <= b2_d;
      gap_q <= gap_d;
      st_q  <= st_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      dz_q  <= dz_d;
      irq_q <= irq_d;
    end
  end

  assign mouse_status_o   = st_q;
  assign mouse_dx_o       = dx_q;
  assign mouse_dy_o       = dy_q;
  assign mouse_dz_o       = dz_q;
  assign send_interrupt_o = irq_q;

endmodule

// File: rtl/ps2_mouse_master_fsm_v2.sv
// rtl/ps2_mouse_master_fsm_v2.sv - PS/2 mouse host: reset, wheel detect, rate set, stream enable
module ps2_mouse_master_fsm_v2
  import ps2_mouse_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 500_000,
  parameter bit         ENABLE_WHEEL   = 1'b1,
  parameter logic [7:0] SAMPLE_RATE    = 8'd100,
  parameter int         MAX_RETRIES    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       send_byte_o,
  output logic [7:0] byte_to_send_o,
  input  logic       byte_sent_i,
  output logic       read_enable_o,
  input  logic [7:0] byte_read_i,
  input  logic [1:0] byte_error_code_i,
  input  logic       byte_ready_i,
  output logic [7:0] mouse_status_o,
  output logic [7:0] mouse_dx_o,
  output logic [7:0] mouse_dy_o,
  output logic [7:0] mouse_dz_o,
  output logic       send_interrupt_o,
  output logic       wheel_mode_o,
  output logic       init_fail_o,
  output logic [3:0] state_dbg_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX = seq_len(ENABLE_WHEEL) - 4'd1;
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    tx_q, tx_d;
  logic          wheel_q, wheel_d;
  logic          fail_q, fail_d;
  logic          timeout, rx_ok, do_adv, do_retry;

  assign timeout = (timer_q == T_LAST);
  assign rx_ok   = (byte_error_code_i == 2'b00);

  // Next state: a received byte always takes priority over a coincident timeout.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    wheel_d  = wheel_q;
    fail_d   = fail_q;
    tx_d     = tx_q;
    do_adv   = 1'b0;
    do_retry = 1'b0;
    case (state_q)
      ST_IDLE: if (timeout) begin
        state_d = ST_SEND;
        idx_d   = 4'd0;
      end
      ST_SEND: if (byte_sent_i) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (byte_ready_i) begin
          if (!rx_ok) begin
            do_retry = 1'b1;
          end else begin
            case (byte_read_i)
              RSP_ACK: begin
                if (idx_q == 4'd0)                           state_d = ST_WAIT_BAT;
                else if (is_get_id_idx(idx_q, ENABLE_WHEEL)) state_d = ST_WAIT_ID;
                else                                         do_adv  = 1'b1;
              end
              RSP_RESEND, RSP_ERROR: do_retry = 1'b1;
              default:               do_retry = 1'b1;
            endcase
          end
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      ST_WAIT_BAT: begin
        if (byte_ready_i) begin
          if (rx_ok && byte_read_i == RSP_BAT_OK) state_d  = ST_WAIT_ID;
          else                                    do_retry = 1'b1;
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      ST_WAIT_ID: begin
        if (byte_ready_i) begin
          if (rx_ok) begin
            if (is_get_id_idx(idx_q, ENABLE_WHEEL)) wheel_d = (byte_read_i == RSP_ID_WHEEL);
            do_adv = 1'b1;
          end else begin
            do_retry = 1'b1;
          end
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      ST_STREAM: ;
      ST_FAIL:   ;
      default:   state_d = ST_IDLE;
    endcase

    if (do_adv) begin
      retry_d = 4'd0;
      if (idx_q == LAST_IDX) begin
        state_d = ST_STREAM;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = ST_SEND;
      end
    end

    if (do_retry) begin
      retry_d = retry_q + 4'd1;
      idx_d   = 4'd0;
      if (retry_d == MAX_R) begin
        state_d = ST_FAIL;
        fail_d  = 1'b1;
      end else begin
        state_d = ST_SEND;
      end
    end

    // Latch the command on entry to SEND so it stays put until the transmitter is done.
    if (state_d == ST_SEND && state_q != ST_SEND) tx_d = cmd_at(idx_d, ENABLE_WHEEL, SAMPLE_RATE);
  end

  // Control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      retry_q <= 4'd0;
      tx_q    <= 8'hFF;
      wheel_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      tx_q    <= tx_d;
      wheel_q <= wheel_d;
      fail_q  <= fail_d;
    end
  end

  // State timer: restarts on every state change and saturates at the timeout value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   timer_q <= '0;
    else if (state_d != state_q) timer_q <= '0;
    else if (!timeout)           timer_q <= timer_q + 1'b1;
  end

  assign send_byte_o    = (state_q == ST_SEND) && (timer_q == '0);
  assign byte_to_send_o = tx_q;
  assign read_enable_o  = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_BAT) ||
                          (state_q == ST_WAIT_ID)  || (state_q == ST_STREAM);
  assign wheel_mode_o   = wheel_q;
  assign init_fail_o    = fail_q;
  assign state_dbg_o    = state_q;

  ps2_mouse_pkt_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_pkt (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .active_i         (state_q == ST_STREAM),
    .wheel_mode_i     (wheel_q),
    .byte_ready_i     (byte_ready_i),
    .byte_read_i      (byte_read_i),
    .rx_ok_i          (rx_ok),
    .mouse_status_o   (mouse_status_o),
    .mouse_dx_o       (mouse_dx_o),
    .mouse_dy_o       (mouse_dy_o),
    .mouse_dz_o       (mouse_dz_o),
    .send_interrupt_o (send_interrupt_o)
  );

endmodule

// File: tb/tb_ps2_mouse_master_fsm_v2.sv
// tb/tb_ps2_mouse_master_fsm_v2.sv - self-checking bench with packet reference model
module tb_ps2_mouse_master_fsm_v2;

  localparam int T = 40;
  localparam logic [7:0] SR = 8'd60;

  logic       clk = 1'b0;
  logic       rst;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent;
  logic       read_enable;
  logic [7:0] byte_read;
  logic [1:0] byte_error_code;
  logic       byte_ready;
  logic [7:0] mouse_status, mouse_dx, mouse_dy, mouse_dz;
  logic       send_interrupt, wheel_mode, init_fail;
  logic [3:0] state_dbg;
  logic       tb_pkt;

  always #5 clk = ~clk;

  ps2_mouse_master_fsm_v2 #(
    .TIMEOUT_CYCLES(T), .ENABLE_WHEEL(1'b1), .SAMPLE_RATE(SR), .MAX_RETRIES(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .send_byte_o(send_byte), .byte_to_send_o(byte_to_send),
    .byte_sent_i(byte_sent), .read_enable_o(read_enable), .byte_read_i(byte_read),
    .byte_error_code_i(byte_error_code), .byte_ready_i(byte_ready),
    .mouse_status_o(mouse_status), .mouse_dx_o(mouse_dx), .mouse_dy_o(mouse_dy),
    .mouse_dz_o(mouse_dz), .send_interrupt_o(send_interrupt), .wheel_mode_o(wheel_mode),
    .init_fail_o(init_fail), .state_dbg_o(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;
  logic [7:0] exp_cmds [11];

  // reference packet model
  int         m_cnt = 0;
  int         m_sil = 0;
  bit         m_wheel = 1'b0;
  logic [7:0] m_buf [4];
  logic [7:0] e_st = 8'h00, e_dx = 8'h00, e_dy = 8'h00, e_dz = 8'h00;
  logic       e_irq = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare, then advance the model with the inputs the next edge will see.
  always @(negedge clk) begin
    if (rst) begin
      m_cnt = 0; m_sil = 0;
      e_st = 8'h00; e_dx = 8'h00; e_dy = 8'h00; e_dz = 8'h00; e_irq = 1'b0;
    end
    if (send_interrupt) irq_cnt++;
    checks++;
    if ({mouse_status, mouse_dx, mouse_dy, mouse_dz, send_interrupt} !== {e_st, e_dx, e_dy, e_dz, e_irq}) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got %h %h %h %h irq=%b expected %h %h %h %h irq=%b",
               $time, mouse_status, mouse_dx, mouse_dy, mouse_dz, send_interrupt,
               e_st, e_dx, e_dy, e_dz, e_irq);
    end
    if (!rst) begin
      e_irq = 1'b0;
      if (byte_ready && tb_pkt) begin
        m_sil = 0;
        if (byte_error_code != 2'b00) begin
          m_cnt = 0;
        end else if (m_cnt == 0) begin
          if (byte_read[3]) begin m_buf[0] = byte_read; m_cnt = 1; end
        end else begin
          m_buf[m_cnt] = byte_read;
          m_cnt++;
          if (m_cnt == (m_wheel ? 4 : 3)) begin
            e_st = m_buf[0]; e_dx = m_buf[1]; e_dy = m_buf[2];
            e_dz = m_wheel ? 8'(int'(m_buf[3][3:0]) - (m_buf[3][3] ? 16 : 0)) : 8'h00;
            e_irq = 1'b1;
            m_cnt = 0;
          end
        end
      end else if (m_cnt > 0) begin
        m_sil++;
        if (m_sil >= T) begin m_cnt = 0; m_sil = 0; end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rx(input logic [7:0] b, input logic [1:0] e, input bit pkt);
    byte_read = b; byte_error_code = e; tb_pkt = pkt; byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0; tb_pkt = 1'b0; byte_error_code = 2'b00; byte_read = 8'($urandom);
  endtask

  task automatic pb(input logic [7:0] b);
    tick(int'($urandom_range(0, 3)));
    pulse_rx(b, 2'b00, 1'b1);
  endtask

  task automatic resp(input logic [7:0] b);
    tick(int'($urandom_range(0, 6)));
    pulse_rx(b, 2'b00, 1'b0);
  endtask

  // mode 0: answer FA, 1: stay silent, 2: answer FE
  task automatic xchg(input logic [7:0] exp, input int mode, output int waited);
    int k;
    k = 0;
    while (!send_byte && k < 3 * T + 20) begin tick(); k++; end
    waited = k;
    chk("send_byte_seen", 32'(send_byte), 32'd1);
    chk("cmd_byte", 32'(byte_to_send), 32'(exp));
    tick();
    chk("send_byte_one_cycle", 32'(send_byte), 32'd0);
    tick(int'($urandom_range(0, 2)));
    chk("cmd_byte_stable", 32'(byte_to_send), 32'(exp));
    byte_sent = 1'b1; tick(); byte_sent = 1'b0;
    if (mode != 1) resp(mode == 2 ? 8'hFE : 8'hFA);
  endtask

  task automatic run_init(input logic [7:0] id, input bit fe_last, output int first_wait);
    int w;
    first_wait = 0;
    for (int pass = 0; pass < (fe_last ? 2 : 1); pass++) begin
      for (int i = 0; i < 11; i++) begin
        xchg(exp_cmds[i], (fe_last && pass == 0 && i == 10) ? 2 : 0, w);
        if (pass == 0 && i == 0) first_wait = w;
        if (i == 0) begin resp(8'hAA); resp(8'h00); end
        else if (i == 7) resp(id);
      end
    end
  endtask

  task automatic post_init(input bit exp_wheel);
    tick(2);
    chk("stream_read_enable", 32'(read_enable), 32'd1);
    chk("wheel_mode", 32'(wheel_mode), 32'(exp_wheel));
    chk("init_fail_clear", 32'(init_fail), 32'd0);
    m_wheel = exp_wheel;
  endtask

  task automatic rand_stream(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      logic [7:0] b;
      logic [1:0] e;
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 2, T + 1)) : int'($urandom_range(0, 4));
      b = 8'($urandom);
      e = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick(gap);
      pulse_rx(b, e, 1'b1);
    end
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base;
    exp_cmds = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF3, SR, 8'hF4};
    rst = 1'b1; byte_sent = 1'b0; byte_ready = 1'b0; byte_read = 8'h00;
    byte_error_code = 2'b00; tb_pkt = 1'b0;
    tick(3);

    // reset values
    chk("rst_send_byte", 32'(send_byte), 32'd0);
    chk("rst_byte_to_send", 32'(byte_to_send), 32'hFF);
    chk("rst_read_enable", 32'(read_enable), 32'd0);
    chk("rst_wheel", 32'(wheel_mode), 32'd0);
    chk("rst_init_fail", 32'(init_fail), 32'd0);
    chk("rst_state_dbg", 32'(state_dbg), 32'd0);

    // wheel device
    rst = 1'b0;
    run_init(8'h03, 1'b0, w);
    chk("idle_wait_cycles", 32'(w), 32'(T));
    post_init(1'b1);
    base = irq_cnt;
    pb(8'h09); pb(8'h01); pb(8'h02); pb(8'h0F);
    tick(2);
    chk("wheel_pkt_status", 32'(mouse_status), 32'h09);
    chk("wheel_pkt_dz_neg", 32'(mouse_dz), 32'hFF);
    pb(8'h00); pb(8'h08); pb(8'h11); pb(8'h22); pb(8'h05);
    tick(2);
    chk("resync_status", 32'(mouse_status), 32'h08);
    chk("resync_dx", 32'(mouse_dx), 32'h11);
    chk("resync_dy", 32'(mouse_dy), 32'h22);
    chk("resync_dz", 32'(mouse_dz), 32'h05);
    chk("wheel_irq_count", 32'(irq_cnt - base), 32'd2);
    rand_stream(60);
    pb(8'h08); pb(8'h33);
    rst = 1'b1; tick();
    chk("midpkt_rst_status", 32'(mouse_status), 32'h00);
    chk("midpkt_rst_wheel", 32'(wheel_mode), 32'd0);
    chk("midpkt_rst_read_enable", 32'(read_enable), 32'd0);
    chk("midpkt_rst_byte_to_send", 32'(byte_to_send), 32'hFF);
    tick(2);

    // plain device
    rst = 1'b0;
    run_init(8'h00, 1'b0, w);
    post_init(1'b0);
    base = irq_cnt;
    pb(8'h08); pb(8'h05); pb(8'hFB);
    tick(2);
    chk("plain_status", 32'(mouse_status), 32'h08);
    chk("plain_dx", 32'(mouse_dx), 32'h05);
    chk("plain_dy", 32'(mouse_dy), 32'hFB);
    chk("plain_dz", 32'(mouse_dz), 32'h00);
    chk("plain_irq_count", 32'(irq_cnt - base), 32'd1);
    base = irq_cnt;
    pb(8'h08); pb(8'h01);
    tick(T + 3);
    pb(8'h08); pb(8'h0A); pb(8'h0B);
    tick(2);
    chk("gap_discard_dx", 32'(mouse_dx), 32'h0A);
    chk("gap_discard_dy", 32'(mouse_dy), 32'h0B);
    chk("gap_discard_irq_count", 32'(irq_cnt - base), 32'd1);
    rand_stream(60);

    // FE on F4 restarts the sequence; rx error inside a packet
    rst = 1'b1; tick(2); rst = 1'b0;
    run_init(8'h03, 1'b1, w);
    post_init(1'b1);
    base = irq_cnt;
    pb(8'h08);
    tick(1); pulse_rx(8'h01, 2'b10, 1'b1);
    pb(8'h02);
    pb(8'h0C); pb(8'h01); pb(8'h02); pb(8'h03);
    tick(2);
    chk("rxerr_status", 32'(mouse_status), 32'h0C);
    chk("rxerr_dz", 32'(mouse_dz), 32'h03);
    chk("rxerr_irq_count", 32'(irq_cnt - base), 32'd1);
    rand_stream(40);

    // silent mouse: three attempts then FAIL
    rst = 1'b1; tick(2); rst = 1'b0;
    for (int a = 0; a < 3; a++) xchg(8'hFF, 1, w);
    tick(T + 5);
    chk("fail_init_fail", 32'(init_fail), 32'd1);
    chk("fail_read_enable", 32'(read_enable), 32'd0);
    w = 0;
    for (int k = 0; k < 3 * T; k++) begin
      if (send_byte) w++;
      tick();
    end
    chk("fail_no_send", 32'(w), 32'd0);
    rst = 1'b1; tick();
    chk("fail_cleared_by_rst", 32'(init_fail), 32'd0);
    rst = 1'b0; tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
